// File: rtl/systolic_stream_sequencer_pkg.sv
// Shared types and sizing for the systolic operand-stream sequencer.
// Fixed array geometry: N_PE PEs, DW-bit operand nibbles, JOB_LEN nibbles per job.
package systolic_pkg;

  localparam int unsigned N_PE    = 8;
  localparam int unsigned DW      = 4;
  localparam int unsigned N_DATA  = 2 * N_PE - 1;
  localparam int unsigned JOB_LEN = 2 * N_PE + N_DATA;
  localparam int unsigned IDX_W   = $clog2(JOB_LEN);
  localparam int unsigned CNT_W   = $clog2(N_DATA);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } phase_t;

  // Position of the current phase's operand within a stored job.
  function automatic logic [IDX_W-1:0] job_index(input phase_t ph, input logic [CNT_W-1:0] cnt);
    logic [IDX_W-1:0] base;
    case (ph)
      LOAD_B:  base = IDX_W'(N_PE);
      COMPUTE: base = IDX_W'(2 * N_PE);
      default: base = '0;
    endcase
    return base + IDX_W'(cnt);
  endfunction

endpackage

// File: rtl/systolic_stream_sequencer_if.sv
// Host write port of the sequencer: valid/ready nibble handshake.
interface systolic_stream_sequencer_if;
  import systolic_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/systolic_stream_sequencer_job_buffer.sv
// Ping-pong job storage: two JOB_LEN-nibble banks with full flags,
// a sequential write pointer and a random-access read port for the replay side.
module seq_job_buffer
  import systolic_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  systolic_stream_sequencer_if.slave wr,
  input  logic                      rel_en,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic                      rd_full,
  output logic [DW-1:0]             rd_data
);

  logic [1:0][JOB_LEN-1:0][DW-1:0] mem_q, mem_d;
  logic [1:0]                      full_q, full_d;
  logic                            wr_sel_q, wr_sel_d;
  logic                            rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]                wr_idx_q, wr_idx_d;
  logic                            wr_fire;

  assign wr.in_ready = !full_q[wr_sel_q];
  assign wr_fire     = wr.in_valid && wr.in_ready;
  assign rd_full     = full_q[rd_sel_q];
  assign rd_data     = mem_q[rd_sel_q][rd_idx];

  // Release and write-completion always target different banks, so both
  // flag updates can be applied in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    wr_idx_d = wr_idx_q;
    if (wr_fire) begin
      mem_d[wr_sel_q][wr_idx_q] = wr.in_data;
      if (wr_idx_q == IDX_W'(JOB_LEN - 1)) begin
        full_d[wr_sel_q] = 1'b1;
        wr_idx_d         = '0;
        wr_sel_d         = !wr_sel_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (rel_en) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/systolic_stream_sequencer.sv
// Replays buffered jobs onto the array operand bus following the fixed
// IDLE/LOAD_W/LOAD_B/COMPUTE/DRAIN schedule. SYSTOLIC_SEQ_HOLD_EN: wait in IDLE until a job is ready.
module systolic_stream_sequencer
  import systolic_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  systolic_stream_sequencer_if.slave wr,
  output logic [DW-1:0]             stream_out,
  output logic [2:0]                phase,
  output logic                      frame_valid,
  output logic                      job_done
);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic             done_q, done_d;
  logic             rel_en;
  logic             rd_full;
  logic [DW-1:0]    rd_data;
  logic [IDX_W-1:0] rd_idx;

  seq_job_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr      (wr),
    .rel_en  (rel_en),
    .rd_idx  (rd_idx),
    .rd_full (rd_full),
    .rd_data (rd_data)
  );

  assign rel_en = (phase_q == DRAIN) && fv_q;
  assign rd_idx = job_index(phase_q, cnt_q);

  always_comb begin
    stream_out = '0;
    if (fv_q && (phase_q == LOAD_W || phase_q == LOAD_B || phase_q == COMPUTE)) begin
      stream_out = rd_data;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    fv_d    = fv_q;
    done_d  = 1'b0;
    unique case (phase_q)
      IDLE: begin
        cnt_d = '0;
        fv_d  = rd_full;
`ifdef SYSTOLIC_SEQ_HOLD_EN
        if (rd_full) phase_d = LOAD_W;
`else
        phase_d = LOAD_W;
`endif
      end
      LOAD_W: begin
        if (cnt_q == CNT_W'(N_PE - 1)) begin
          phase_d = LOAD_B;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOAD_B: begin
        if (cnt_q == CNT_W'(N_PE - 1)) begin
          phase_d = COMPUTE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COMPUTE: begin
        if (cnt_q == CNT_W'(N_DATA - 1)) begin
          phase_d = DRAIN;
          cnt_d   = '0;
          done_d  = fv_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        phase_d = IDLE;
        cnt_d   = '0;
        fv_d    = 1'b0;
      end
      default: begin
        phase_d = IDLE;
        cnt_d   = '0;
        fv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      fv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      fv_q    <= fv_d;
      done_q  <= done_d;
    end
  end

  assign phase       = phase_q;
  assign frame_valid = fv_q;
  assign job_done    = done_q;

endmodule

// File: tb/tb_systolic_stream_sequencer.sv
// Scoreboard bench for systolic_stream_sequencer: accepted job nibbles are queued
// and popped as the DUT streams them; schedule, commit and flow control are modelled.
module tb_systolic_stream_sequencer;
  import systolic_pkg::*;

  localparam int unsigned FRAME = 2 * N_PE + N_DATA + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] stream_out;
  logic [2:0]    phase;
  logic          frame_valid;
  logic          job_done;

  systolic_stream_sequencer_if wr ();

  systolic_stream_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .wr          (wr),
    .stream_out  (stream_out),
    .phase       (phase),
    .frame_valid (frame_valid),
    .job_done    (job_done)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int unsigned   pos_m = 0;
  bit            fv_m  = 1'b0;
  int unsigned   full_m = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] part_q[$];
  bit            fire_m, rel_m;

  function automatic phase_t exp_phase(input int unsigned p);
    if (p == 0)                   return IDLE;
    if (p <= N_PE)                return LOAD_W;
    if (p <= 2 * N_PE)            return LOAD_B;
    if (p <= 2 * N_PE + N_DATA)   return COMPUTE;
    return DRAIN;
  endfunction

  always @(negedge clk) begin
    chk_eq("phase", 32'(phase), 32'(exp_phase(pos_m)));
    chk_eq("frame_valid", 32'(frame_valid), 32'(fv_m));
    chk_eq("job_done", 32'(job_done), 32'((pos_m == FRAME - 1) && fv_m));
    chk_eq("in_ready", 32'(wr.in_ready), 32'(full_m < 2));
    if (fv_m && pos_m >= 1 && pos_m <= JOB_LEN) begin
      if (exp_q.size() == 0) chk_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      else                   chk_eq("stream", 32'(stream_out), 32'(exp_q.pop_front()));
    end else begin
      chk_eq("stream_zero", 32'(stream_out), 32'd0);
    end

    if (rst) begin
      pos_m  = 0;
      fv_m   = 1'b0;
      full_m = 0;
      exp_q.delete();
      part_q.delete();
    end else begin
      fire_m = wr.in_valid && (full_m < 2);
      rel_m  = (pos_m == FRAME - 1) && fv_m;
      if (pos_m == 0)              fv_m = (full_m > 0);
      else if (pos_m == FRAME - 1) fv_m = 1'b0;
`ifdef SYSTOLIC_SEQ_HOLD_EN
      if (!(pos_m == 0 && full_m == 0)) pos_m = (pos_m == FRAME - 1) ? 0 : pos_m + 1;
`else
      pos_m = (pos_m == FRAME - 1) ? 0 : pos_m + 1;
`endif
      if (fire_m) begin
        part_q.push_back(wr.in_data);
        if (part_q.size() == JOB_LEN) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          full_m++;
        end
      end
      if (rel_m) full_m--;
    end
  end

  logic [DW-1:0] job_buf [128];

  task automatic send_nibbles(input int unsigned n);
    int unsigned i = 0;
    int unsigned guard = 0;
    while (i < n && guard < 2000) begin
      @(posedge clk); #1;
      wr.in_valid = 1'b1;
      wr.in_data  = job_buf[i];
      @(negedge clk);
      if (wr.in_ready) i++;
      guard++;
    end
    @(posedge clk); #1;
    wr.in_valid = 1'b0;
    if (i < n) chk_eq("send_timeout", i, n);
  endtask

  task automatic fill_random(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) job_buf[i] = DW'($urandom_range(0, 15));
  endtask

  task automatic wait_drained(input int unsigned limit);
    int unsigned c = 0;
    while ((exp_q.size() != 0 || full_m != 0) && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned c;
    wr.in_valid = 1'b0;
    wr.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    idle_cycles(40);

    for (int unsigned i = 0; i < N_PE; i++) job_buf[i] = DW'(i + 1);
    for (int unsigned i = 0; i < N_PE; i++) job_buf[N_PE + i] = DW'(9 + i);
    for (int unsigned i = 0; i < N_DATA; i++) job_buf[2 * N_PE + i] = DW'(i + 1);
    send_nibbles(JOB_LEN);
    wait_drained(200);
    idle_cycles(5);

    fill_random(3 * JOB_LEN);
    send_nibbles(3 * JOB_LEN);
    wait_drained(400);
    idle_cycles(5);

    // One full job plus a partial one, then reset mid-COMPUTE of the valid frame.
    fill_random(JOB_LEN + 10);
    send_nibbles(JOB_LEN + 10);
    c = 0;
    while (!(phase == 3'(COMPUTE) && frame_valid) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk_eq("wait_compute", 32'(phase == 3'(COMPUTE) && frame_valid), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_in_ready", 32'(wr.in_ready), 32'd1);
    idle_cycles(40);

    fill_random(JOB_LEN);
    send_nibbles(JOB_LEN);
    wait_drained(200);
    idle_cycles(5);

    chk_eq("partial_empty", 32'(part_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
